// File: rtl/stage_sequencer.sv
// Stage sequencer: steps the IDU through fetch / decode-type / decode-specific / execute,
// runs the instruction-fetch handshake, starts the CU and waits for its completion.
// Optional build macro PERF_COUNTERS_EN adds cycle_count and instret outputs.
module stage_sequencer #(
  parameter int unsigned          TIMEOUT_W   = 8,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = {TIMEOUT_W{1'b1}}
) (
  input  logic        soc_clk,
  input  logic        SEQ_reset,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr_in,
  output logic [31:0] instruction,
  output logic [1:0]  stage_counter,
  output logic        idu_flush,
  input  logic [5:0]  instruction_to_cu,
  input  logic        invalid_instruction,
  output logic        cu_start,
  input  logic        cu_done,
  input  logic        redirect,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
`endif
);

  // StExec is the single EXEC entry cycle; StWait is the rest of EXEC (both show stage 3).
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StDec1  = 3'd2;
  localparam logic [2:0] StDec2  = 3'd3;
  localparam logic [2:0] StExec  = 3'd4;
  localparam logic [2:0] StWait  = 3'd5;
  localparam logic [2:0] StHalt  = 3'd6;
  localparam logic [2:0] StFault = 3'd7;

  localparam logic [5:0] OpEcall  = 6'd39;
  localparam logic [5:0] OpEbreak = 6'd40;

  logic [2:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [31:0]          instr_q, instr_d;
  logic [1:0]           code_q, code_d;
  logic                 flush_q, flush_d;
  logic                 start;

  // Next-state, wait counter and fetch latch
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    instr_d = instr_q;
    code_d  = code_q;
    flush_d = 1'b0;
    start   = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
          wait_d  = '0;
        end
      end
      StFetch: begin
        // A late ack still wins over the timeout in the same cycle
        if (imem_ack) begin
          instr_d = instr_in;
          state_d = StDec1;
        end else if (wait_q == TIMEOUT_MAX) begin
          state_d = StFault;
          code_d  = 2'b10;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDec1: state_d = StDec2;
      StDec2: state_d = StExec;
      StExec: begin
        wait_d = '0;
        if (invalid_instruction) begin
          state_d = StFault;
          code_d  = 2'b01;
        end else if (instruction_to_cu == OpEcall || instruction_to_cu == OpEbreak) begin
          state_d = StHalt;
        end else begin
          start   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cu_done) begin
          flush_d = redirect;
          wait_d  = '0;
          state_d = run ? StFetch : StIdle;
        end else if (wait_q == TIMEOUT_MAX) begin
          state_d = StFault;
          code_d  = 2'b11;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHalt, StFault: ;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset overrides any ack/done seen in the same cycle
  always_ff @(posedge soc_clk) begin
    if (SEQ_reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      instr_q <= '0;
      code_q  <= 2'b00;
      flush_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      code_q  <= code_d;
      flush_q <= flush_d;
    end
  end

  // Output decode from the current state
  always_comb begin
    case (state_q)
      StFetch: stage_counter = 2'd0;
      StDec1:  stage_counter = 2'd1;
      StDec2:  stage_counter = 2'd2;
      default: stage_counter = 2'd3;
    endcase
  end

  assign imem_req    = (state_q == StFetch);
  assign cu_start    = start;
  assign instruction = instr_q;
  assign idu_flush   = flush_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);
  assign fault_code  = code_q;

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;

  // Active-cycle and retired-instruction counters, free-running with wrap
  always_ff @(posedge soc_clk) begin
    if (SEQ_reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != StIdle && state_q != StHalt && state_q != StFault) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (state_q == StWait && cu_done) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instret     = instret_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: each instruction is described by its ack delay, CU delay,
// opcode and flags; expected per-cycle outputs follow directly from those values.
module tb_stage_sequencer;

  localparam int TMAX = 255;

  logic        soc_clk = 1'b0;
  logic        SEQ_reset;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic [31:0] instruction;
  logic [1:0]  stage_counter;
  logic        idu_flush;
  logic [5:0]  instruction_to_cu;
  logic        invalid_instruction;
  logic        cu_start;
  logic        cu_done;
  logic        redirect;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count;
  logic [31:0] instret;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_cycles = 0;
  int exp_instret = 0;

  stage_sequencer dut (
    .soc_clk             (soc_clk),
    .SEQ_reset           (SEQ_reset),
    .run                 (run),
    .imem_req            (imem_req),
    .imem_ack            (imem_ack),
    .instr_in            (instr_in),
    .instruction         (instruction),
    .stage_counter       (stage_counter),
    .idu_flush           (idu_flush),
    .instruction_to_cu   (instruction_to_cu),
    .invalid_instruction (invalid_instruction),
    .cu_start            (cu_start),
    .cu_done             (cu_done),
    .redirect            (redirect),
    .halted              (halted),
    .fault               (fault),
    .fault_code          (fault_code)
`ifdef PERF_COUNTERS_EN
    ,
    .cycle_count         (cycle_count),
    .instret             (instret)
`endif
  );

  always #5 soc_clk = ~soc_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    imem_ack            = 1'b0;
    instr_in            = $urandom;
    cu_done             = 1'b0;
    redirect            = 1'b0;
    invalid_instruction = 1'b0;
    instruction_to_cu   = 6'd0;
  endtask

  task automatic check_perf();
`ifdef PERF_COUNTERS_EN
    check_eq("cycle_count", cycle_count, 32'(exp_cycles));
    check_eq("instret", instret, 32'(exp_instret));
`endif
  endtask

  // Reset, then two idle cycles with run low
  task automatic do_reset();
    clear_inputs();
    run       = 1'b0;
    SEQ_reset = 1'b1;
    @(negedge soc_clk);
    #1;
    check_eq("rst_stage", 32'(stage_counter), 32'd3);
    check_eq("rst_instr", instruction, 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_start", 32'(cu_start), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_code", 32'(fault_code), 32'd0);
    check_eq("rst_flush", 32'(idu_flush), 32'd1);
    SEQ_reset   = 1'b0;
    exp_cycles  = 0;
    exp_instret = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge soc_clk);
      #1;
      check_eq("idle_flush", 32'(idu_flush), 32'd0);
      check_eq("idle_stage", 32'(stage_counter), 32'd3);
      check_eq("idle_req", 32'(imem_req), 32'd0);
    end
    check_perf();
    run = 1'b1;
    @(negedge soc_clk);
  endtask

  // Terminal state: outputs hold for several cycles even with run high
  task automatic check_terminal(input bit exp_halt, input bit exp_fault, input logic [1:0] code);
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("term_halted", 32'(halted), 32'(exp_halt));
      check_eq("term_fault", 32'(fault), 32'(exp_fault));
      check_eq("term_code", 32'(fault_code), 32'(code));
      check_eq("term_stage", 32'(stage_counter), 32'd3);
      check_eq("term_req", 32'(imem_req), 32'd0);
      check_eq("term_start", 32'(cu_start), 32'd0);
      check_perf();
      @(negedge soc_clk);
    end
  endtask

  // Entered at the first FETCH cycle. Delays above TMAX mean the ack/done never comes.
  task automatic do_instr(input int ack_dly, input int done_dly, input logic [31:0] word,
                          input logic [5:0] op, input bit inv, input bit redir,
                          input bit run_end, input bit exp_flush, output bit term);
    bit exp_start;
    int n;
    term = 1'b0;
    check_perf();
    n = (ack_dly > TMAX) ? TMAX : ack_dly;
    for (int i = 0; i <= n; i++) begin
      imem_ack = (i == ack_dly);
      instr_in = (i == ack_dly) ? word : $urandom;
      run      = 1'($urandom);
      #1;
      check_eq("fetch_req", 32'(imem_req), 32'd1);
      check_eq("fetch_stage", 32'(stage_counter), 32'd0);
      check_eq("fetch_flush", 32'(idu_flush), (i == 0) ? 32'(exp_flush) : 32'd0);
      check_eq("fetch_start", 32'(cu_start), 32'd0);
      @(negedge soc_clk);
      exp_cycles++;
    end
    imem_ack = 1'b0;
    instr_in = $urandom;
    if (ack_dly > TMAX) begin
      check_terminal(1'b0, 1'b1, 2'b10);
      term = 1'b1;
      return;
    end
    #1;
    check_eq("dec1_stage", 32'(stage_counter), 32'd1);
    check_eq("dec1_instr", instruction, word);
    check_eq("dec1_req", 32'(imem_req), 32'd0);
    check_eq("dec1_fault", 32'(fault), 32'd0);
    @(negedge soc_clk);
    exp_cycles++;
    #1;
    check_eq("dec2_stage", 32'(stage_counter), 32'd2);
    check_eq("dec2_instr", instruction, word);
    @(negedge soc_clk);
    exp_cycles++;
    invalid_instruction = inv;
    instruction_to_cu   = op;
    exp_start = !inv && op != 6'd39 && op != 6'd40;
    #1;
    check_eq("exec_stage", 32'(stage_counter), 32'd3);
    check_eq("exec_start", 32'(cu_start), 32'(exp_start));
    @(negedge soc_clk);
    exp_cycles++;
    invalid_instruction = 1'b0;
    instruction_to_cu   = 6'd0;
    if (inv) begin
      check_terminal(1'b0, 1'b1, 2'b01);
      term = 1'b1;
      return;
    end
    if (!exp_start) begin
      check_terminal(1'b1, 1'b0, 2'b00);
      term = 1'b1;
      return;
    end
    n = (done_dly > TMAX) ? TMAX : done_dly;
    for (int j = 0; j <= n; j++) begin
      cu_done             = (j == done_dly);
      redirect            = (j == done_dly) ? redir : 1'($urandom);
      run                 = (j == done_dly) ? run_end : 1'($urandom);
      instruction_to_cu   = 6'($urandom_range(39, 40));
      invalid_instruction = 1'($urandom);
      #1;
      check_eq("wait_stage", 32'(stage_counter), 32'd3);
      check_eq("wait_start", 32'(cu_start), 32'd0);
      check_eq("wait_req", 32'(imem_req), 32'd0);
      @(negedge soc_clk);
      exp_cycles++;
    end
    clear_inputs();
    if (done_dly > TMAX) begin
      check_terminal(1'b0, 1'b1, 2'b11);
      term = 1'b1;
      return;
    end
    exp_instret++;
    run = run_end;
    if (!run_end) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        #1;
        check_eq("idle_stage", 32'(stage_counter), 32'd3);
        check_eq("idle_req", 32'(imem_req), 32'd0);
        check_eq("idle_halt", 32'(halted | fault), 32'd0);
        if (k == n - 1) run = 1'b1;
        @(negedge soc_clk);
      end
    end
  endtask

  initial begin
    bit t;
    bit prev_flush;
    bit rd;
    bit re;
    do_reset();

    // Zero-wait addi stream
    for (int k = 0; k < 3; k++) do_instr(0, 0, 32'h0050_0093, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, t);
    // Delayed ack
    do_instr(3, 1, 32'h1234_5678, 6'd7, 1'b0, 1'b0, 1'b1, 1'b0, t);

    // Random instruction stream
    prev_flush = 1'b0;
    for (int k = 0; k < 30; k++) begin
      re = ($urandom_range(0, 3) != 0);
      rd = re && 1'($urandom);
      do_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
               6'($urandom_range(0, 38)), 1'b0, rd, re, prev_flush, t);
      prev_flush = rd;
    end
    // Redirect while stopping: ends in IDLE
    do_instr(0, 0, 32'hAAAA_5555, 6'd3, 1'b0, 1'b1, 1'b0, prev_flush, t);
    do_instr(0, 0, 32'h0000_0013, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0, t);

    // ebreak, ecall, invalid (invalid beats ebreak)
    do_instr(1, 0, 32'h0010_0073, 6'd40, 1'b0, 1'b0, 1'b1, 1'b0, t);
    do_reset();
    do_instr(0, 0, 32'h0000_0073, 6'd39, 1'b0, 1'b0, 1'b1, 1'b0, t);
    do_reset();
    do_instr(0, 0, 32'hFFFF_FFFF, 6'd40, 1'b1, 1'b0, 1'b1, 1'b0, t);

    // Fetch timeout, ack on the last allowed cycle, CU timeout
    do_reset();
    do_instr(TMAX + 1, 0, 32'h0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, t);
    do_reset();
    do_instr(TMAX, 0, 32'hCAFE_F00D, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, t);
    do_instr(0, TMAX, 32'h0BAD_CAFE, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, t);
    do_instr(0, TMAX + 1, 32'h1111_2222, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, t);

    // Reset during FETCH with a pending ack
    do_reset();
    imem_ack  = 1'b1;
    instr_in  = 32'hDEAD_BEEF;
    SEQ_reset = 1'b1;
    @(negedge soc_clk);
    #1;
    check_eq("midrst_instr", instruction, 32'd0);
    check_eq("midrst_stage", 32'(stage_counter), 32'd3);
    check_eq("midrst_req", 32'(imem_req), 32'd0);
    check_eq("midrst_flush", 32'(idu_flush), 32'd1);
    do_reset();
    do_instr(0, 0, 32'h0050_0093, 6'd5, 1'b0, 1'b0, 1'b1, 1'b0, t);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
